// File: rtl/spi_master_param_if.sv
// Processor-side control/status bundle for spi_master_param.
// The SPI pins stay as plain ports on the master itself.
interface spi_master_param_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int DIV_W  = 8
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] wdata;
    logic [SEL_W-1:0]  ss_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rdata;

    modport master (
        output start, abort, wdata, ss_sel, cpol, cpha, lsb_first, clk_div,
        input  busy, done, rdata
    );

    modport slave (
        input  start, abort, wdata, ss_sel, cpol, cpha, lsb_first, clk_div,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_master_param.sv
// Parametrised SPI master: all four CPOL/CPHA modes, programmable SCLK half-period,
// selectable bit order and per-transfer chip select. SCLK is a registered output.
module spi_master_param #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 2,
    parameter int DIV_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    spi_master_param_if.slave     bus,
    input  logic                  miso,
    output logic                  sclk,
    output logic                  mosi,
    output logic [2**SEL_W-1:0]   ss_n
);
    localparam int NUM_SS = 2**SEL_W;
    localparam int TOG_W  = $clog2(2*DATA_W+1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t            state_r;
    logic [DIV_W-1:0]  cnt_r;
    logic [TOG_W-1:0]  tog_r;
    logic [DATA_W-1:0] tx_r;
    logic [DATA_W-1:0] rx_r;
    logic [DIV_W-1:0]  div_r;
    logic              cpol_r;
    logic              cpha_r;
    logic              lsb_r;

    logic              period_end_s;
    logic              toggle_s;
    logic              leading_s;
    logic              sample_s;
    logic              shift_s;

    function automatic logic tx_head(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] tx_adv(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
    endfunction

    // Received bits are assembled so that loopback reproduces the transmitted word.
    function automatic logic [DATA_W-1:0] rx_ins(input logic [DATA_W-1:0] r, input logic b,
                                                 input logic lsb);
        return lsb ? {b, r[DATA_W-1:1]} : {r[DATA_W-2:0], b};
    endfunction

    // Edge classification: tog_r counts SCLK toggles already made, so even means leading next.
    always_comb begin
        period_end_s = (cnt_r == div_r);
        toggle_s     = 1'b0;
        leading_s    = ~tog_r[0];
        if (state_r == ST_SETUP) begin
            toggle_s = period_end_s;
        end else if (state_r == ST_XFER) begin
            toggle_s = period_end_s && (tog_r != TOG_W'(2*DATA_W));
        end else begin
            toggle_s = 1'b0;
        end
        sample_s = toggle_s && (leading_s != cpha_r);
        shift_s  = toggle_s && (leading_s == cpha_r) && (tog_r != TOG_W'(2*DATA_W-1));
    end

    // Transfer sequencer with all outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            tog_r     <= '0;
            tx_r      <= '0;
            rx_r      <= '0;
            div_r     <= '0;
            cpol_r    <= 1'b0;
            cpha_r    <= 1'b0;
            lsb_r     <= 1'b0;
            sclk      <= 1'b0;
            mosi      <= 1'b0;
            ss_n      <= '1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b0;
            bus.rdata <= '0;
        end else if ((state_r != ST_IDLE) && bus.abort) begin
            state_r  <= ST_IDLE;
            ss_n     <= '1;
            sclk     <= cpol_r;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    bus.done <= 1'b0;
                    sclk     <= cpol_r;
                    ss_n     <= '1;
                    if (bus.start) begin
                        div_r    <= bus.clk_div;
                        cpol_r   <= bus.cpol;
                        cpha_r   <= bus.cpha;
                        lsb_r    <= bus.lsb_first;
                        sclk     <= bus.cpol;
                        ss_n     <= ~({{(NUM_SS-1){1'b0}}, 1'b1} << bus.ss_sel);
                        bus.busy <= 1'b1;
                        cnt_r    <= '0;
                        tog_r    <= '0;
                        rx_r     <= '0;
                        state_r  <= ST_SETUP;
                        // CPHA=0 slaves sample on the first edge, so bit 0 must already be out.
                        if (!bus.cpha) begin
                            mosi <= tx_head(bus.wdata, bus.lsb_first);
                            tx_r <= tx_adv(bus.wdata, bus.lsb_first);
                        end else begin
                            tx_r <= bus.wdata;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SETUP, ST_XFER: begin
                    cnt_r <= period_end_s ? '0 : cnt_r + DIV_W'(1);
                    if (toggle_s) begin
                        sclk  <= ~sclk;
                        tog_r <= tog_r + TOG_W'(1);
                    end else begin
                        tog_r <= tog_r;
                    end
                    if (sample_s) begin
                        rx_r <= rx_ins(rx_r, miso, lsb_r);
                    end else begin
                        rx_r <= rx_r;
                    end
                    if (shift_s) begin
                        mosi <= tx_head(tx_r, lsb_r);
                        tx_r <= tx_adv(tx_r, lsb_r);
                    end else begin
                        tx_r <= tx_r;
                    end
                    if ((state_r == ST_SETUP) && period_end_s) begin
                        state_r <= ST_XFER;
                    end else if ((state_r == ST_XFER) && period_end_s &&
                                 (tog_r == TOG_W'(2*DATA_W))) begin
                        state_r <= ST_HOLD;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_HOLD: begin
                    cnt_r <= period_end_s ? '0 : cnt_r + DIV_W'(1);
                    if (period_end_s) begin
                        ss_n      <= '1;
                        bus.busy  <= 1'b0;
                        bus.done  <= 1'b1;
                        bus.rdata <= rx_r;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r <= ST_HOLD;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    ss_n     <= '1;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule
